instr_issuer: RTL and testbench

//   Program-side initiator for the control unit's run/done handshake.

---
 rtl/instr_issuer.sv | 176 +++++++++++++++++
 tb/tb_instr_issuer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issuer.sv
// instr_issuer
//   Program-side initiator for the processor's run/done handshake. It holds a
//   small writable program store and fetches 9-bit instruction words. It
//   launches each word into the datapath with a one-cycle run pulse and
//   supplies the immediate word for mvi. It then waits for done and advances
//   the program counter.
//
//   Word format: [8:6] opcode, [5:3] Rx, [2:0] Ry.
//   Opcode 001 is mvi (two words). Opcode 111 is halt and is never issued.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   prog_we    program-store write enable (taken only when not busy)
//   prog_addr  program-store write address
//   prog_data  program-store write data
//   start      begin execution at address 0 (from IDLE/HALT/ERR)
//   stop       stop after the current instruction completes
//   done       processor instruction-complete strobe
//   run        one-cycle launch pulse to the processor
//   din        instruction word (ISSUE) or mvi immediate (WAIT)
//   pc         address of the current instruction
//   busy       high in FETCH/ISSUE/WAIT
//   halted     high in HALT
//   error      high in ERR (done timeout)
module instr_issuer #(
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [8:0]    prog_data,
  input  logic          start,
  input  logic          stop,
  input  logic          done,
  output logic          run,
  output logic [8:0]    din,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          error
);

  localparam int         DEPTH     = 2 ** AW;
  localparam int         TW        = $clog2(TIMEOUT) + 1;
  localparam logic [2:0] OP_MVI    = 3'b001;
  localparam logic [2:0] OP_HALT   = 3'b111;
  localparam logic [8:0] HALT_WORD = 9'h1C0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_HALT, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    instr_q;
  logic [8:0]    imm_q;
  logic [8:0]    din_q;
  logic [AW-1:0] pc_q;
  logic [TW-1:0] timer_q;
  logic          stop_pend_q;

  logic [AW-1:0] pc_inc1;
  logic [AW-1:0] pc_inc2;
  logic [8:0]    fetch_word;
  logic [8:0]    fetch_imm;
  logic          instr_is_mvi;
  logic          timer_last;
  logic          busy_d;

  // Address arithmetic wraps naturally at AW bits. An mvi in the last word
  // therefore takes its immediate from word 0 and continues at word 1.
  assign pc_inc1      = pc_q + AW'(1);
  assign pc_inc2      = pc_q + AW'(2);
  assign fetch_word   = mem_q[pc_q];
  assign fetch_imm    = mem_q[pc_inc1];
  assign instr_is_mvi = (instr_q[8:6] == OP_MVI);
  // The timer restarts at 0 on the first WAIT cycle. Expiry is detected on
  // the cycle whose increment would reach TIMEOUT-1.
  assign timer_last   = (timer_q == TW'(TIMEOUT - 2));
  assign busy_d       = (state_d == S_FETCH) || (state_d == S_ISSUE) ||
                        (state_d == S_WAIT);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = (fetch_word[8:6] == OP_HALT) ? S_HALT : S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the expiry cycle still counts as completion.
        if (done) begin
          state_d = (stop_pend_q || stop) ? S_IDLE : S_FETCH;
        end else if (timer_last) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Program store, pc, timer, stop request and din register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= HALT_WORD;
      pc_q        <= '0;
      timer_q     <= '0;
      stop_pend_q <= 1'b0;
      din_q       <= '0;
    end else begin
      // Writes while busy are dropped. A write in the same cycle as start
      // lands before the first fetch.
      if (prog_we && !busy) mem_q[prog_addr] <= prog_data;

      case (state_q)
        S_IDLE, S_HALT, S_ERR: begin
          if (start) pc_q <= '0;
        end
        S_FETCH: begin
          if (state_d == S_ISSUE) din_q <= fetch_word;
        end
        S_ISSUE: begin
          timer_q <= '0;
          din_q   <= instr_is_mvi ? imm_q : instr_q;
        end
        S_WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (done) pc_q <= instr_is_mvi ? pc_inc2 : pc_inc1;
        end
        default: ;
      endcase

      // A pending stop is dropped whenever execution leaves the busy
      // states. A later start from HALT/ERR therefore runs freely.
      if (busy && stop) stop_pend_q <= 1'b1;
      if (!busy_d)      stop_pend_q <= 1'b0;
    end
  end

  // Instruction and immediate latches. These are pure data and need no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH) begin
      instr_q <= fetch_word;
      imm_q   <= fetch_imm;
    end
  end

  // Output decode
  always_comb begin
    run    = (state_q == S_ISSUE);
    busy   = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
    halted = (state_q == S_HALT);
    error  = (state_q == S_ERR);
    din    = din_q;
    pc     = pc_q;
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Testbench for instr_issuer. A scoreboard queue holds the expected
// {pc, din} of every run pulse. A monitor pops and compares on each pulse.
// A responder drives done relative to run according to a mode.
module tb_instr_issuer;

  localparam int AW      = 4;
  localparam int TIMEOUT = 8;

  logic          clk       = 1'b0;
  logic          resetn    = 1'b0;
  logic          prog_we   = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [8:0]    prog_data = '0;
  logic          start     = 1'b0;
  logic          stop      = 1'b0;
  logic          done      = 1'b0;
  logic          run;
  logic [8:0]    din;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          error;

  instr_issuer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .stop      (stop),
    .done      (done),
    .run       (run),
    .din       (din),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [8:0]    din;
  } exp_t;

  exp_t sb_q[$];
  int   run_times[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   resp_mode = 0;     // 0: never done, 1: pulse resp_delay cycles after run, 2: always high
  int   resp_delay = 1;
  int   resp_cnt = 1000;
  logic prev_run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int a, input int d);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = 9'(d);
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_run(input int p, input int d);
    exp_t e;
    e.pc  = AW'(p);
    e.din = 9'(d);
    sb_q.push_back(e);
  endtask

  function automatic logic flag(input int w);
    case (w)
      0:       return run;
      1:       return halted;
      2:       return error;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_flag(input string name, input int w, input int maxc);
    int k = 0;
    while (flag(w) !== 1'b1 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (flag(w) !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: condition not reached within %0d cycles", name, maxc);
    end
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // done responder
  initial forever begin
    @(negedge clk);
    if (run === 1'b1) resp_cnt = 0;
    else if (resp_cnt < 1000) resp_cnt++;
    case (resp_mode)
      0:       done = 1'b0;
      1:       done = (resp_cnt == resp_delay);
      default: done = 1'b1;
    endcase
  end

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (run === 1'b1) begin
      exp_t e;
      chk("run_not_back_to_back", 32'(prev_run), 0);
      run_times.push_back(cyc);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_run: pc=%0d din=0x%0h, expected no run", pc, din);
      end else begin
        e = sb_q.pop_front();
        chk("run_pc", 32'(pc), 32'(e.pc));
        chk("run_din", 32'(din), 32'(e.din));
      end
    end
    prev_run = run;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int first;
    int bad_gaps;

    // Reset state
    resetn = 1'b0;
    nclk(2);
    chk("rst_run", 32'(run), 0);
    chk("rst_din", 32'(din), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_error", 32'(error), 0);
    resetn = 1'b1;
    nclk(1);

    // 1: mvi then halt, done 3 cycles after run
    load(0, 'h040); load(1, 'h005); load(2, 'h1C0);
    resp_mode = 1; resp_delay = 3;
    expect_run(0, 'h040);
    pulse_start();
    wait_flag("t1_run", 0, 5);
    nclk(1);
    chk("t1_din_wait_imm", 32'(din), 'h005);
    chk("t1_busy_wait", 32'(busy), 1);
    wait_flag("t1_halt", 1, 20);
    chk("t1_pc_halt", 32'(pc), 2);
    chk("t1_din_hold", 32'(din), 'h005);
    chk("t1_busy_halt", 32'(busy), 0);

    // 2: add, sub, halt with done one cycle after each run
    load(0, 'h081); load(1, 'h0C8);
    resp_mode = 1; resp_delay = 1;
    expect_run(0, 'h081);
    expect_run(1, 'h0C8);
    pulse_start();
    chk("t2_halted_cleared", 32'(halted), 0);
    chk("t2_busy_fetch", 32'(busy), 1);
    wait_flag("t2_halt", 1, 30);
    chk("t2_pc_halt", 32'(pc), 2);

    // 3: all words add, done always high, wrap, then stop
    for (int i = 0; i < 16; i++) load(i, 'h081);
    resp_mode = 2;
    first = run_times.size();
    for (int k = 0; k < 20; k++) expect_run(k % 16, 'h081);
    pulse_start();
    nclk(57);
    stop = 1'b1;
    nclk(1);
    stop = 1'b0;
    wait_flag("t3_idle", 3, 10);
    chk("t3_pc_after_stop", 32'(pc), 4);
    chk("t3_halted", 32'(halted), 0);
    chk("t3_error", 32'(error), 0);
    chk("t3_run_count", 32'(run_times.size() - first), 20);
    bad_gaps = 0;
    for (int i = first + 1; i < run_times.size(); i++)
      if (run_times[i] - run_times[i-1] != 3) bad_gaps++;
    chk("t3_run_spacing_bad", 32'(bad_gaps), 0);

    // 4: mvi in the last word takes its immediate from word 0
    load(0, 'h007); load(15, 'h040);
    resp_mode = 2;
    expect_run(0, 'h007);
    for (int k = 1; k < 15; k++) expect_run(k, 'h081);
    expect_run(15, 'h040);
    pulse_start();
    nclk(45);
    stop = 1'b1;
    nclk(1);
    stop = 1'b0;
    nclk(1);
    chk("t4_din_wrap_imm", 32'(din), 'h007);
    chk("t4_busy_wait", 32'(busy), 1);
    nclk(1);
    chk("t4_pc_wrap", 32'(pc), 1);
    chk("t4_idle", 32'(busy), 0);

    // 5: timeout; a write during WAIT must be dropped
    load(0, 'h081);
    resp_mode = 0;
    expect_run(0, 'h081);
    pulse_start();
    wait_flag("t5_run", 0, 5);
    nclk(1);
    load(0, 'h1C0);
    nclk(5);
    chk("t5_no_error_yet", 32'(error), 0);
    chk("t5_busy_before_err", 32'(busy), 1);
    nclk(1);
    chk("t5_error", 32'(error), 1);
    chk("t5_busy_err", 32'(busy), 0);
    expect_run(0, 'h081);
    pulse_start();
    chk("t5_error_cleared", 32'(error), 0);
    chk("t5_pc_restart", 32'(pc), 0);
    wait_flag("t5_run2", 0, 5);
    wait_flag("t5_error2", 2, 15);

    // 6: async reset mid-WAIT restores the store
    expect_run(0, 'h081);
    pulse_start();
    wait_flag("t6_run", 0, 5);
    nclk(2);
    chk("t6_busy_wait", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    chk("t6_rst_run", 32'(run), 0);
    chk("t6_rst_pc", 32'(pc), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_din", 32'(din), 0);
    nclk(1);
    resetn = 1'b1;
    nclk(1);
    load(0, 'h000);
    resp_mode = 1; resp_delay = 1;
    expect_run(0, 'h000);
    pulse_start();
    wait_flag("t6_halt", 1, 20);
    chk("t6_pc_word1_halt", 32'(pc), 1);

    nclk(5);
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
